ibex_prefetch_buffer_nreq: RTL and testbench

Parametrised next-generation instruction prefetch buffer between the IF stage and the instruction bus (OBI-style req/gnt/rvalid). It supports a configurable number of outstanding bus requests and a configurable FIFO depth, tracks a per-request address and PMP error, and discards responses to requests cancelled by a branch. Optional stop-on-error mode halts sequential prefetch after a faulting fetch until the next branch. Output is whole aligned words with address; compressed-instruction alignment is done downstream.

---
 rtl/ibex_prefetch_pkg.sv | 23 ++
 rtl/ibex_prefetch_fifo_n.sv | 73 +++++++
 rtl/ibex_prefetch_buffer_nreq.sv | 169 ++++++++++++++++
 tb/tb_ibex_prefetch_buffer_nreq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ibex_prefetch_pkg.sv
// Shared types for the N-request prefetch buffer.
//   out_entry_t  : one outstanding bus request (word address, discard-on-return, PMP fault)
//   fifo_entry_t : one fetched word handed to the IF stage (data, address, fetch error)
//   level_width  : bit width of a fill counter able to hold 0..depth
package ibex_prefetch_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        discard;
        logic        pmp_err;
    } out_entry_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        err;
    } fifo_entry_t;

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ibex_prefetch_fifo_n.sv
// Shift-register word FIFO for the prefetch buffer.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : flush all entries (wins over push)
//   push_i       : write wdata_i at the tail
//   pop_i        : drop the head entry
//   rdata_o      : head entry, zero while empty
//   valid_o      : head entry valid
//   level_o      : number of stored entries
module ibex_prefetch_fifo_n import ibex_prefetch_pkg::*; #(
    parameter int unsigned DEPTH = 3,
    localparam int unsigned LvlW = level_width(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            push_i,
    input  fifo_entry_t     wdata_i,
    input  logic            pop_i,
    output fifo_entry_t     rdata_o,
    output logic            valid_o,
    output logic [LvlW-1:0] level_o
);

    fifo_entry_t     mem_q [DEPTH];
    fifo_entry_t     mem_d [DEPTH];
    logic [LvlW-1:0] level_q, level_d;
    logic            pop_ok;

    always_comb begin
        pop_ok  = pop_i & (level_q != '0);
        mem_d   = mem_q;
        level_d = level_q;
        if (clear_i) begin
            level_d = '0;
        end else begin
            if (pop_ok) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
                level_d = level_q - LvlW'(1);
            end
            if (push_i) begin
                // Tail slot is the level after any same-cycle pop shift.
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (LvlW'(i) == level_d) begin
                        mem_d[i] = wdata_i;
                    end
                end
                level_d = level_d + LvlW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            mem_q   <= mem_d;
        end
    end

    assign valid_o = (level_q != '0);
    assign rdata_o = valid_o ? mem_q[0] : '0;
    assign level_o = level_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (push_i && !clear_i && !pop_ok) |-> (32'(level_q) < DEPTH));

endmodule

// File: rtl/ibex_prefetch_buffer_nreq.sv
// Instruction prefetch buffer with several outstanding OBI requests.
//   req_i/branch_i/addr_i       : fetch enable, redirect + flush, redirect target
//   ready_i/valid_o/rdata_o/... : aligned word output (data, address, error) to the IF stage
//   instr_*                     : OBI instruction bus (req/gnt address phase, rvalid response)
//   busy_o                      : requests outstanding or being issued
//   level_o                     : output FIFO fill count
module ibex_prefetch_buffer_nreq import ibex_prefetch_pkg::*; #(
    parameter int unsigned NUM_REQS    = 2,
    parameter int unsigned FIFO_DEPTH  = 3,
    parameter bit          STOP_ON_ERR = 1'b1,
    localparam int unsigned LvlW = level_width(FIFO_DEPTH),
    localparam int unsigned CntW = $clog2(NUM_REQS + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            branch_i,
    input  logic [31:0]     addr_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [31:0]     rdata_o,
    output logic [31:0]     addr_o,
    output logic            err_o,
    output logic            instr_req_o,
    input  logic            instr_gnt_i,
    output logic [31:0]     instr_addr_o,
    input  logic [31:0]     instr_rdata_i,
    input  logic            instr_err_i,
    input  logic            instr_pmp_err_i,
    input  logic            instr_rvalid_i,
    output logic            busy_o,
    output logic [LvlW-1:0] level_o
);

    out_entry_t      out_q [NUM_REQS];
    out_entry_t      out_d [NUM_REQS];
    logic [CntW-1:0] out_cnt_q, out_cnt_d, cnt_after_pop;
    logic            held_q, held_d;
    logic            held_discard_q, held_discard_d;
    logic [31:0]     held_addr_q, held_addr_d;
    logic [31:0]     fetch_addr_q, fetch_addr_d;
    logic            stop_q, stop_d;

    logic            gnt_ok, new_req, push_out, pop_out;
    logic            fifo_push, fifo_pop, fifo_valid;
    logic [31:0]     addr_mux;
    logic [LvlW-1:0] level;
    out_entry_t      head, push_entry;
    fifo_entry_t     fifo_wdata, fifo_rdata;

    always_comb begin
        // A PMP-faulted address phase never reaches the bus, so it counts as granted.
        gnt_ok  = instr_gnt_i | instr_pmp_err_i;
        new_req = req_i & ~stop_q & (32'(out_cnt_q) < NUM_REQS)
                & (((32'(level) + 32'(out_cnt_q)) < FIFO_DEPTH) | branch_i);
        instr_req_o  = held_q | new_req;
        addr_mux     = held_q ? held_addr_q : (branch_i ? addr_i : fetch_addr_q);
        instr_addr_o = {addr_mux[31:2], 2'b00};
        busy_o       = (out_cnt_q != '0) | instr_req_o;

        head     = out_q[0];
        pop_out  = (out_cnt_q != '0) & (instr_rvalid_i | head.pmp_err);
        push_out = instr_req_o & gnt_ok;

        push_entry.addr    = instr_addr_o;
        push_entry.discard = held_q & (held_discard_q | branch_i);
        push_entry.pmp_err = instr_pmp_err_i;

        // Outstanding queue: pop shift, branch discard, then push at the new tail.
        out_d         = out_q;
        cnt_after_pop = out_cnt_q;
        if (pop_out) begin
            for (int unsigned i = 0; i + 1 < NUM_REQS; i++) begin
                out_d[i] = out_q[i+1];
            end
            cnt_after_pop = out_cnt_q - CntW'(1);
        end
        if (branch_i) begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                out_d[i].discard = 1'b1;
            end
        end
        if (push_out) begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                if (CntW'(i) == cnt_after_pop) begin
                    out_d[i] = push_entry;
                end
            end
        end
        out_cnt_d = cnt_after_pop + CntW'(push_out);

        // An ungranted request must keep address stable; a branch only marks it for discard.
        held_d         = held_q;
        held_addr_d    = held_addr_q;
        held_discard_d = held_discard_q;
        if (instr_req_o & ~gnt_ok) begin
            held_d         = 1'b1;
            held_addr_d    = instr_addr_o;
            held_discard_d = held_q & (held_discard_q | branch_i);
        end else begin
            held_d         = 1'b0;
            held_discard_d = 1'b0;
        end

        fetch_addr_d = fetch_addr_q;
        if (branch_i) begin
            fetch_addr_d = {addr_i[31:2], 2'b00} + ((new_req & ~held_q) ? 32'd4 : 32'd0);
        end else if (new_req & ~held_q) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
        end

        // Responses popped in a branch cycle belong to the old stream.
        fifo_push        = pop_out & ~head.discard & ~branch_i;
        fifo_wdata.rdata = instr_rdata_i;
        fifo_wdata.addr  = head.addr;
        fifo_wdata.err   = instr_err_i | head.pmp_err;
        fifo_pop         = fifo_valid & ready_i;

        stop_d = STOP_ON_ERR ? (~branch_i & (stop_q | (fifo_push & fifo_wdata.err))) : 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_cnt_q      <= '0;
            held_q         <= 1'b0;
            held_discard_q <= 1'b0;
            held_addr_q    <= '0;
            fetch_addr_q   <= '0;
            stop_q         <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            out_cnt_q      <= out_cnt_d;
            held_q         <= held_d;
            held_discard_q <= held_discard_d;
            held_addr_q    <= held_addr_d;
            fetch_addr_q   <= fetch_addr_d;
            stop_q         <= stop_d;
            out_q          <= out_d;
        end
    end

    ibex_prefetch_fifo_n #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (branch_i),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .level_o (level)
    );

    assign valid_o = fifo_valid;
    assign rdata_o = fifo_rdata.rdata;
    assign addr_o  = fifo_rdata.addr;
    assign err_o   = fifo_rdata.err;
    assign level_o = level;

    a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_rvalid_i |-> (out_cnt_q != '0));
    a_push_has_room: assert property (@(posedge clk_i) disable iff (rst_i)
        push_out |-> (32'(cnt_after_pop) < NUM_REQS));

endmodule

// File: tb/tb_ibex_prefetch_buffer_nreq.sv
module tb_ibex_prefetch_buffer_nreq;
    import ibex_prefetch_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i, branch_i, ready_i;
    logic [31:0] addr_i;
    logic        valid_o, err_o, instr_req_o, busy_o;
    logic [31:0] rdata_o, addr_o, instr_addr_o;
    logic        instr_gnt_i, instr_err_i, instr_pmp_err_i, instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic [1:0]  level_o;

    int errors = 0;
    int checks = 0;

    ibex_prefetch_buffer_nreq #(
        .NUM_REQS    (2),
        .FIFO_DEPTH  (3),
        .STOP_ON_ERR (1'b1)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_i           (req_i),
        .branch_i        (branch_i),
        .addr_i          (addr_i),
        .ready_i         (ready_i),
        .valid_o         (valid_o),
        .rdata_o         (rdata_o),
        .addr_o          (addr_o),
        .err_o           (err_o),
        .instr_req_o     (instr_req_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_addr_o    (instr_addr_o),
        .instr_rdata_i   (instr_rdata_i),
        .instr_err_i     (instr_err_i),
        .instr_pmp_err_i (instr_pmp_err_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .busy_o          (busy_o),
        .level_o         (level_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic idle();
        req_i = 0; branch_i = 0; addr_i = '0; ready_i = 0;
        instr_gnt_i = 0; instr_err_i = 0; instr_pmp_err_i = 0; instr_rvalid_i = 0;
        instr_rdata_i = '0;
    endtask

    // Each cycle: drive at negedge, look at outputs 1 time unit later.
    task automatic cyc();
        @(negedge clk_i);
        idle();
    endtask

    task automatic rsp(input logic [31:0] a);
        instr_rvalid_i = 1; instr_rdata_i = dat(a);
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1;
        repeat (2) @(negedge clk_i);
        #1;
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", instr_req_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
        checks++; if (addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", addr_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        checks++; if (level_o !== 2'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", level_o); end
        rst_i = 0;
    endtask

    task automatic test_sequential();
        cyc(); req_i = 1; branch_i = 1; addr_i = 32'h102; instr_gnt_i = 1; ready_i = 1; #1;
        checks++; if (instr_addr_o !== 32'h100) begin errors++; $display("FAIL seq_a0: got %h want 100", instr_addr_o); end
        cyc(); req_i = 1; instr_gnt_i = 1; ready_i = 1; rsp(32'h100); #1;
        checks++; if (instr_addr_o !== 32'h104) begin errors++; $display("FAIL seq_a1: got %h want 104", instr_addr_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL seq_lat: got %b want 0", valid_o); end
        cyc(); req_i = 1; instr_gnt_i = 1; ready_i = 1; rsp(32'h104); #1;
        checks++; if (instr_addr_o !== 32'h108) begin errors++; $display("FAIL seq_a2: got %h want 108", instr_addr_o); end
        checks++; if (valid_o !== 1'b1 || addr_o !== 32'h100) begin errors++; $display("FAIL seq_o0: got %b/%h want 1/100", valid_o, addr_o); end
        checks++; if (rdata_o !== dat(32'h100)) begin errors++; $display("FAIL seq_d0: got %h want %h", rdata_o, dat(32'h100)); end
        cyc(); ready_i = 1; rsp(32'h108); #1;
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL seq_noreq: got %b want 0", instr_req_o); end
        checks++; if (valid_o !== 1'b1 || addr_o !== 32'h104) begin errors++; $display("FAIL seq_o1: got %b/%h want 1/104", valid_o, addr_o); end
        cyc(); ready_i = 1; #1;
        checks++; if (addr_o !== 32'h108 || rdata_o !== dat(32'h108)) begin errors++; $display("FAIL seq_o2: got %h/%h want 108/%h", addr_o, rdata_o, dat(32'h108)); end
        cyc(); #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL seq_end: got valid=%b busy=%b want 0/0", valid_o, busy_o); end
    endtask

    task automatic test_held_branch();
        cyc(); req_i = 1; branch_i = 1; addr_i = 32'h100; instr_gnt_i = 1; ready_i = 1;
        cyc(); req_i = 1; ready_i = 1; rsp(32'h100); #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h104) begin errors++; $display("FAIL hold_a0: got %b/%h want 1/104", instr_req_o, instr_addr_o); end
        cyc(); req_i = 1; ready_i = 1; branch_i = 1; addr_i = 32'h200; #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h104) begin errors++; $display("FAIL hold_a1: got %b/%h want 1/104", instr_req_o, instr_addr_o); end
        checks++; if (valid_o !== 1'b1 || addr_o !== 32'h100) begin errors++; $display("FAIL hold_o0: got %b/%h want 1/100", valid_o, addr_o); end
        cyc(); req_i = 1; #1;
        checks++; if (instr_addr_o !== 32'h104) begin errors++; $display("FAIL hold_a2: got %h want 104", instr_addr_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL hold_flush: got %b want 0", valid_o); end
        cyc(); req_i = 1; instr_gnt_i = 1; #1;
        checks++; if (instr_addr_o !== 32'h104) begin errors++; $display("FAIL hold_a3: got %h want 104", instr_addr_o); end
        cyc(); req_i = 1; instr_gnt_i = 1; rsp(32'h104); #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin errors++; $display("FAIL hold_tgt: got %b/%h want 1/200", instr_req_o, instr_addr_o); end
        cyc(); rsp(32'h200); #1;
        checks++; if (valid_o !== 1'b0 || level_o !== 2'd0) begin errors++; $display("FAIL hold_drop: got %b/%0d want 0/0", valid_o, level_o); end
        cyc(); ready_i = 1; #1;
        checks++; if (valid_o !== 1'b1 || addr_o !== 32'h200 || rdata_o !== dat(32'h200)) begin errors++; $display("FAIL hold_o1: got %b/%h/%h want 1/200/%h", valid_o, addr_o, rdata_o, dat(32'h200)); end
        cyc(); #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL hold_end: got %b/%b want 0/0", valid_o, busy_o); end
    endtask

    task automatic test_credit();
        cyc(); req_i = 1; branch_i = 1; addr_i = 32'h400; instr_gnt_i = 1;
        cyc(); req_i = 1; instr_gnt_i = 1; #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h404) begin errors++; $display("FAIL cred_a1: got %b/%h want 1/404", instr_req_o, instr_addr_o); end
        cyc(); req_i = 1; instr_gnt_i = 1; #1;
        checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL cred_nreq: got req=%b busy=%b want 0/1", instr_req_o, busy_o); end
        rsp(32'h400);
        cyc(); req_i = 1; instr_gnt_i = 1; rsp(32'h404); #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h408 || level_o !== 2'd1) begin errors++; $display("FAIL cred_a2: got %b/%h/%0d want 1/408/1", instr_req_o, instr_addr_o, level_o); end
        cyc(); req_i = 1; instr_gnt_i = 1; rsp(32'h408); #1;
        checks++; if (instr_req_o !== 1'b0 || level_o !== 2'd2) begin errors++; $display("FAIL cred_sum: got %b/%0d want 0/2", instr_req_o, level_o); end
        cyc(); req_i = 1; #1;
        checks++; if (instr_req_o !== 1'b0 || level_o !== 2'd3) begin errors++; $display("FAIL cred_full: got %b/%0d want 0/3", instr_req_o, level_o); end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] exp_a;
            exp_a = 32'h400 + 32'(4 * k);
            cyc(); ready_i = 1; #1;
            checks++; if (valid_o !== 1'b1 || addr_o !== exp_a || rdata_o !== dat(exp_a)) begin errors++; $display("FAIL cred_drain%0d: got %b/%h/%h want 1/%h/%h", k, valid_o, addr_o, rdata_o, exp_a, dat(exp_a)); end
        end
        cyc(); #1;
        checks++; if (valid_o !== 1'b0 || level_o !== 2'd0) begin errors++; $display("FAIL cred_end: got %b/%0d want 0/0", valid_o, level_o); end
    endtask

    task automatic test_pmp_err();
        cyc(); req_i = 1; branch_i = 1; addr_i = 32'h300; instr_pmp_err_i = 1; #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h300) begin errors++; $display("FAIL pmp_a: got %b/%h want 1/300", instr_req_o, instr_addr_o); end
        cyc(); #1;
        checks++; if (busy_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL pmp_busy: got %b/%b want 1/0", busy_o, valid_o); end
        cyc(); req_i = 1; ready_i = 1; #1;
        checks++; if (valid_o !== 1'b1 || addr_o !== 32'h300 || err_o !== 1'b1) begin errors++; $display("FAIL pmp_word: got %b/%h/%b want 1/300/1", valid_o, addr_o, err_o); end
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL pmp_stop0: got %b want 0", instr_req_o); end
        cyc(); req_i = 1; #1;
        checks++; if (instr_req_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL pmp_stop1: got %b/%b want 0/0", instr_req_o, valid_o); end
        cyc(); req_i = 1; branch_i = 1; addr_i = 32'h500; #1;
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL pmp_brcyc: got %b want 0", instr_req_o); end
        cyc(); req_i = 1; instr_gnt_i = 1; #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h500) begin errors++; $display("FAIL pmp_resume: got %b/%h want 1/500", instr_req_o, instr_addr_o); end
        cyc(); rsp(32'h500);
        cyc(); ready_i = 1; #1;
        checks++; if (valid_o !== 1'b1 || addr_o !== 32'h500 || err_o !== 1'b0) begin errors++; $display("FAIL pmp_after: got %b/%h/%b want 1/500/0", valid_o, addr_o, err_o); end
        cyc();
    endtask

    task automatic test_branch_flush();
        cyc(); req_i = 1; branch_i = 1; addr_i = 32'h600; instr_gnt_i = 1;
        cyc(); req_i = 1; instr_gnt_i = 1;
        cyc(); req_i = 1; rsp(32'h600);
        cyc(); req_i = 1; instr_gnt_i = 1; #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h608) begin errors++; $display("FAIL fl_a: got %b/%h want 1/608", instr_req_o, instr_addr_o); end
        cyc(); branch_i = 1; addr_i = 32'h700; #1;
        checks++; if (level_o !== 2'd1 || valid_o !== 1'b1 || addr_o !== 32'h600 || instr_req_o !== 1'b0) begin errors++; $display("FAIL fl_pre: got lvl=%0d v=%b a=%h req=%b want 1/1/600/0", level_o, valid_o, addr_o, instr_req_o); end
        cyc(); rsp(32'h604); #1;
        checks++; if (valid_o !== 1'b0 || level_o !== 2'd0 || busy_o !== 1'b1) begin errors++; $display("FAIL fl_clr: got v=%b lvl=%0d busy=%b want 0/0/1", valid_o, level_o, busy_o); end
        cyc(); rsp(32'h608); #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL fl_late0: got %b/%b want 0/1", valid_o, busy_o); end
        cyc(); #1;
        checks++; if (valid_o !== 1'b0 || level_o !== 2'd0 || busy_o !== 1'b0) begin errors++; $display("FAIL fl_late1: got v=%b lvl=%0d busy=%b want 0/0/0", valid_o, level_o, busy_o); end
    endtask

    task automatic test_reset_mid();
        cyc(); req_i = 1; branch_i = 1; addr_i = 32'h800; instr_gnt_i = 1;
        cyc(); req_i = 1; instr_gnt_i = 1;
        cyc(); rst_i = 1; instr_rvalid_i = 1; instr_rdata_i = 32'hFFFF_FFFF; instr_err_i = 1; #1;
        checks++; if (busy_o !== 1'b0 || instr_req_o !== 1'b0 || level_o !== 2'd0) begin errors++; $display("FAIL rmid_now: got busy=%b req=%b lvl=%0d want 0/0/0", busy_o, instr_req_o, level_o); end
        @(negedge clk_i); #1;
        checks++; if (valid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0 || addr_o !== 32'h0) begin errors++; $display("FAIL rmid_out: got %b/%h/%b/%h want 0/0/0/0", valid_o, rdata_o, err_o, addr_o); end
        cyc(); rst_i = 0; #1;
        checks++; if (valid_o !== 1'b0 || level_o !== 2'd0 || busy_o !== 1'b0) begin errors++; $display("FAIL rmid_rel: got %b/%0d/%b want 0/0/0", valid_o, level_o, busy_o); end
        cyc(); req_i = 1; instr_gnt_i = 1; #1;
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin errors++; $display("FAIL rmid_fa: got %b/%h want 1/0", instr_req_o, instr_addr_o); end
        cyc(); rsp(32'h0);
        cyc(); ready_i = 1; #1;
        checks++; if (valid_o !== 1'b1 || addr_o !== 32'h0 || rdata_o !== dat(32'h0)) begin errors++; $display("FAIL rmid_w: got %b/%h/%h want 1/0/%h", valid_o, addr_o, rdata_o, dat(32'h0)); end
        cyc(); #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rmid_end: got %b/%b want 0/0", valid_o, busy_o); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_held_branch();
        test_credit();
        test_pmp_err();
        test_branch_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
